cube_pow: RTL and testbench
===========================

// Module: cube_pow
// PURPOSE
//   Sequential cuber: computes y = x^3 for an unsigned input using one shared
//   radix-2 shift-add multiplier, reused for two passes (x*x, then (x*x)*x).
//   Inverse companion of the cubicroot block; same start/busy handshake, so
//   the two can be chained (cube_pow -> cubicroot) for round-trip checks.
//   One adder, no hardware multiplier, fixed latency.
// PARAMETERS
//   WIDTH  8  input width in bits; output is 3*WIDTH bits, so no overflow.
// PORTS
//   clk      in   1          clock, all logic on rising edge
//   rst      in   1          reset, synchronous, active-high
//   start    in   1          request; sampled only in IDLE
//   x_in     in   WIDTH      operand; latched on the accepting edge
//   y_out    out  3*WIDTH    result x^3; holds last result until next completion
//   busy_o   out  1          high from the accepting edge until the result is written
//   done_o   out  1          one-cycle pulse, coincident with the y_out update
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, y_out=0, busy_o=0, done_o=0, and all
//     internal regs (x_r, acc, mcand, mplier, bit counter) = 0. Abandons any op
//     in flight; no done_o pulse, y_out not updated with a partial value.
//   States: IDLE -> SQ -> CU -> FIN -> IDLE.
//   IDLE: if start=1: x_r<=x_in, mcand<=x_in (zero-ext to 3W), mplier<=x_in,
//     acc<=0, cnt<=0, busy_o<=1, go SQ. Otherwise stay; outputs held.
//   SQ (exactly WIDTH cycles): each cycle if mplier[0] acc<=acc+mcand;
//     mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1. On last cycle
//     (cnt=WIDTH-1): load mcand<=the final sum (= x*x, 2W bits, zero-ext),
//     mplier<=x_r, acc<=0, cnt<=0, go CU.
//   CU (exactly WIDTH cycles): same step as SQ. On last cycle go FIN with
//     acc holding the final sum x^3.
//   FIN (1 cycle): y_out<=acc, done_o<=1, busy_o<=0, go IDLE. done_o returns
//     to 0 on the following edge.
//   Latency: start sampled at edge E0 -> busy_o=1 after E0 -> y_out/done_o
//     updated and busy_o=0 after edge E0+2*WIDTH+1 (17 edges for WIDTH=8).
//   Adder: single 3W-bit adder shared by SQ and CU; mcand shifts are 3W-bit
//     logical, bits shifted out are zero by construction (no wrap possible).
//   start while busy_o=1 (SQ/CU/FIN): ignored, not queued.
//   x_in changes while busy: no effect; x_r used for the second pass.
//   start held high continuously: FIN -> IDLE, next op accepted at the IDLE
//     edge, so back-to-back ops are spaced 2*WIDTH+2 edges apart.
//   start and rst together: rst wins.
//   x=0: runs full latency, y_out=0, done_o still pulses.
// TESTING
//   1. x_in=0, 1, 2, 6 -> y_out=0, 1, 8, 216; done_o one cycle each.
//   2. x_in=255 -> y_out=16581375 (0xFD02FF); x_in=128 -> 2097152 (0x200000).
//   3. Timing: start at edge E0 -> busy_o high for exactly 17 cycles, done_o
//      high only in the cycle after edge E0+17, y_out stable until next done.
//   4. Mid-op abuse: pulse start and change x_in 6->3 at cycle 5 of an x=6 op
//      -> result 216, only one done_o, no second op launched.
//   5. Reset at cycle 9 of x=200 op -> next edge busy_o=0, y_out=0, no done_o;
//      then x=5 -> 125 with normal 17-cycle latency.
//   6. Sweep x=0..255 vs model x*x*x; plus loopback x=0..6 through cubicroot
//      (y_out[7:0] as its input) -> returns x.

Source files
------------

// File: rtl/cube_pow.sv
// Sequential cuber: y = x^3 using one shared shift-add multiplier over two passes
// (x*x, then (x*x)*x). Fixed latency of 2*WIDTH+1 cycles from the accepting edge.
module cube_pow #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     x_in,
   output logic [3*WIDTH-1:0]   y_out,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int unsigned YW = 3 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SQ,
      S_CU,
      S_FIN
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [WIDTH-1:0] r_x;
   logic [YW-1:0]    r_acc;
   logic [YW-1:0]    r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CW-1:0]    r_cnt;

   logic             w_last;
   logic [YW-1:0]    w_sum;

   assign w_last = (r_cnt == CW'(WIDTH - 1));
   // Single shared adder for both multiply passes
   assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_SQ;
         S_SQ:    if (w_last) w_next = S_CU;
         S_CU:    if (w_last) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x      <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         y_out    <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x      <= x_in;
                  r_mcand  <= YW'(x_in);
                  r_mplier <= x_in;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  busy_o   <= 1'b1;
               end
            end
            S_SQ, S_CU: begin
               r_acc    <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_cnt <= '0;
                  // End of first pass: the square becomes the multiplicand for x
                  if (r_state == S_SQ) begin
                     r_mcand  <= w_sum;
                     r_mplier <= r_x;
                     r_acc    <= '0;
                  end
               end
            end
            S_FIN: begin
               y_out  <= r_acc;
               done_o <= 1'b1;
               busy_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cube_pow.sv
// Self-checking bench for cube_pow: directed corner cases, timing, abuse,
// randomized and exhaustive checks against an arithmetic x^3 model.
module tb_cube_pow;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned LAT   = 2 * WIDTH + 1;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [WIDTH-1:0]     x_in;
   logic [3*WIDTH-1:0]   y_out;
   logic                 busy_o;
   logic                 done_o;

   int checks = 0;
   int errors = 0;

   cube_pow #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .x_in   (x_in),
      .y_out  (y_out),
      .busy_o (busy_o),
      .done_o (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3*WIDTH-1:0] model_cube(input int unsigned x);
      longint unsigned v;
      v = longint'(x) * longint'(x) * longint'(x);
      return (3*WIDTH)'(v);
   endfunction

   // Behaviour of the companion cube-root block: floor cube root
   function automatic int unsigned model_cbrt(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   // Launch one op and wait (bounded) for done_o; sampling is 1ns after each edge
   task automatic do_op(input logic [WIDTH-1:0] x, output logic [3*WIDTH-1:0] y,
                        output int busy_cnt, output int n, output bit early);
      logic [3*WIDTH-1:0] y0;
      y0 = y_out;
      early = 1'b0;
      busy_cnt = 0;
      n = 0;
      @(negedge clk);
      start = 1'b1;
      x_in  = x;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done_o && n < 40) begin
         if (busy_o) busy_cnt++;
         if (y_out !== y0) early = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      y = y_out;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; x_in = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (y_out !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: y=%0d busy=%b done=%b, required 0/0/0", y_out, busy_o, done_o);
      end
      @(negedge clk);
      start = 1'b1; x_in = 8'd9;
      @(posedge clk); #1;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_beats_start: busy=%b, required 0", busy_o);
      end
      @(negedge clk);
      start = 1'b0; rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] xs [6];
      logic [3*WIDTH-1:0] y;
      int bc, n;
      bit early;
      xs = '{8'd0, 8'd1, 8'd2, 8'd6, 8'd255, 8'd128};
      for (int i = 0; i < 6; i++) begin
         do_op(xs[i], y, bc, n, early);
         checks++;
         if (n >= 40 || y !== model_cube(xs[i])) begin
            errors++;
            $display("FAIL basic x=%0d: y=%0d (n=%0d), required %0d", xs[i], y, n, model_cube(xs[i]));
         end
         @(posedge clk); #1;
         checks++;
         if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL done_width x=%0d: done=%b one cycle later, required 0", xs[i], done_o);
         end
      end
   endtask

   task automatic test_timing();
      logic [3*WIDTH-1:0] y;
      int bc, n;
      bit early;
      do_op(8'd7, y, bc, n, early);
      checks++;
      if (n != LAT || bc != LAT) begin
         errors++;
         $display("FAIL latency: done after %0d edges, busy %0d cycles, required %0d/%0d", n, bc, LAT, LAT);
      end
      checks++;
      if (busy_o !== 1'b0 || y !== 24'd343) begin
         errors++;
         $display("FAIL fin_state: busy=%b y=%0d, required 0/343", busy_o, y);
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL y_hold_during_op: y_out changed before done, required stable");
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (y_out !== 24'd343 || done_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL y_hold_idle: y=%0d done=%b busy=%b, required 343/0/0", y_out, done_o, busy_o);
      end
   endtask

   task automatic test_midop();
      int dones = 0;
      logic [3*WIDTH-1:0] last_y;
      bit busy_after = 1'b0;
      bit seen = 1'b0;
      last_y = '0;
      @(negedge clk);
      start = 1'b1; x_in = 8'd6;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1; x_in = 8'd3;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done_o) begin dones++; last_y = y_out; seen = 1'b1; end
         else if (seen && busy_o) busy_after = 1'b1;
      end
      checks++;
      if (dones != 1 || last_y !== 24'd216 || busy_after) begin
         errors++;
         $display("FAIL midop_abuse: dones=%0d y=%0d relaunch=%b, required 1/216/0", dones, last_y, busy_after);
      end
   endtask

   task automatic test_reset_midop();
      logic [3*WIDTH-1:0] y;
      int bc, n;
      bit early;
      int dones = 0;
      @(negedge clk);
      start = 1'b1; x_in = 8'd200;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy_o !== 1'b0 || y_out !== '0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_midop: busy=%b y=%0d done=%b, required 0/0/0", busy_o, y_out, done_o);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done_o) dones++;
      end
      checks++;
      if (dones != 0 || y_out !== '0) begin
         errors++;
         $display("FAIL reset_abandon: dones=%0d y=%0d, required 0/0", dones, y_out);
      end
      do_op(8'd5, y, bc, n, early);
      checks++;
      if (y !== 24'd125 || n != LAT) begin
         errors++;
         $display("FAIL after_reset x=5: y=%0d lat=%0d, required 125/%0d", y, n, LAT);
      end
   endtask

   task automatic test_back_to_back();
      int first = -1;
      int second = -1;
      @(negedge clk);
      start = 1'b1; x_in = 8'd3;
      for (int i = 0; i < 60 && second < 0; i++) begin
         @(posedge clk); #1;
         if (done_o) begin
            if (first < 0) first = i;
            else second = i;
         end
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (second < 0 || (second - first) != 2 * WIDTH + 2 || y_out !== 24'd27) begin
         errors++;
         $display("FAIL back_to_back: spacing=%0d y=%0d, required %0d/27", second - first, y_out, 2 * WIDTH + 2);
      end
      repeat (LAT + 2) @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      logic [3*WIDTH-1:0] y;
      int bc, n;
      bit early;
      logic [WIDTH-1:0] x;
      for (int i = 0; i < 40; i++) begin
         x = WIDTH'($urandom);
         do_op(x, y, bc, n, early);
         checks++;
         if (y !== model_cube(x) || n != LAT) begin
            errors++;
            $display("FAIL random x=%0d: y=%0d lat=%0d, required %0d/%0d", x, y, n, model_cube(x), LAT);
         end
      end
   endtask

   task automatic test_sweep();
      logic [3*WIDTH-1:0] y;
      int bc, n;
      bit early;
      int bad = 0;
      for (int x = 0; x < 256; x++) begin
         do_op(WIDTH'(x), y, bc, n, early);
         checks++;
         if (y !== model_cube(x)) begin
            errors++;
            bad++;
            if (bad < 10)
               $display("FAIL sweep x=%0d: y=%0d, required %0d", x, y, model_cube(x));
         end
      end
   endtask

   task automatic test_loopback();
      logic [3*WIDTH-1:0] y;
      int bc, n;
      bit early;
      int unsigned r;
      for (int x = 0; x <= 6; x++) begin
         do_op(WIDTH'(x), y, bc, n, early);
         r = model_cbrt(int'(y[7:0]));
         checks++;
         if (r != x) begin
            errors++;
            $display("FAIL loopback x=%0d: root=%0d, required %0d", x, r, x);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; x_in = '0;
      test_reset();
      test_basic();
      test_timing();
      test_midop();
      test_reset_midop();
      test_back_to_back();
      test_random();
      test_sweep();
      test_loopback();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
